program_loader: RTL and testbench

//   Upstream boot stage for the accumulator CPU. Accepts program bytes over a valid/ready stream and

---
 rtl/program_loader.sv | 144 ++++++++++++++
 tb/tb_program_loader.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/program_loader.sv
// Boot-stage program loader: streams bytes into the 32x8 program memory
// while holding the CPU in reset, then releases it and times the run.
module program_loader #(
  parameter int unsigned AW = 5,
  parameter int unsigned DW = 8,
  parameter int unsigned CW = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          in_valid,
  input  logic [DW-1:0] in_data,
  input  logic          in_last,
  output logic          in_ready,
  output logic          mem_wr,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_data,
  output logic          cpu_rst,
  input  logic          cpu_halt,
  output logic          done,
  output logic          error,
  output logic [AW:0]   byte_count,
  output logic [CW-1:0] run_cycles
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_FLUSH,
    S_RUN,
    S_DONE,
    S_ERR
  } state_t;

  state_t        state, state_nx;
  logic [AW-1:0] ptr, ptr_nx;
  logic          in_ready_nx;
  logic          mem_wr_nx;
  logic [AW-1:0] mem_addr_nx;
  logic [DW-1:0] mem_data_nx;
  logic          cpu_rst_nx;
  logic          done_nx;
  logic          error_nx;
  logic [AW:0]   byte_count_nx;
  logic [CW-1:0] run_cycles_nx;
  logic          accept;
  logic          ptr_max;

  // in_ready is registered and only ever high in LOAD, so this is the handshake.
  assign accept  = (state == S_LOAD) && in_valid && in_ready;
  assign ptr_max = &ptr;

  // State register and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      ptr        <= '0;
      in_ready   <= 1'b0;
      mem_wr     <= 1'b0;
      mem_addr   <= '0;
      mem_data   <= '0;
      cpu_rst    <= 1'b1;
      done       <= 1'b0;
      error      <= 1'b0;
      byte_count <= '0;
      run_cycles <= '0;
    end else begin
      state      <= state_nx;
      ptr        <= ptr_nx;
      in_ready   <= in_ready_nx;
      mem_wr     <= mem_wr_nx;
      mem_addr   <= mem_addr_nx;
      mem_data   <= mem_data_nx;
      cpu_rst    <= cpu_rst_nx;
      done       <= done_nx;
      error      <= error_nx;
      byte_count <= byte_count_nx;
      run_cycles <= run_cycles_nx;
    end
  end

  // Next-state and next-output logic; outputs hold unless a state acts on them.
  always_comb begin
    state_nx      = state;
    ptr_nx        = ptr;
    mem_wr_nx     = 1'b0;
    mem_addr_nx   = mem_addr;
    mem_data_nx   = mem_data;
    cpu_rst_nx    = cpu_rst;
    done_nx       = done;
    error_nx      = error;
    byte_count_nx = byte_count;
    run_cycles_nx = run_cycles;

    case (state)
      S_IDLE, S_DONE, S_ERR: begin
        if (start) begin
          state_nx      = S_LOAD;
          ptr_nx        = '0;
          byte_count_nx = '0;
          run_cycles_nx = '0;
          done_nx       = 1'b0;
          error_nx      = 1'b0;
          cpu_rst_nx    = 1'b1;
        end
      end
      S_LOAD: begin
        if (accept) begin
          mem_wr_nx     = 1'b1;
          mem_addr_nx   = ptr;
          mem_data_nx   = in_data;
          byte_count_nx = byte_count + (AW + 1)'(1);
          // Pointer saturates at the top address; leaving LOAD makes that final.
          if (!ptr_max) ptr_nx = ptr + AW'(1);
          if (in_last) begin
            state_nx = S_FLUSH;
          end else if (ptr_max) begin
            state_nx = S_ERR;
            error_nx = 1'b1;
          end
        end
      end
      S_FLUSH: begin
        // The last write pulse is on the bus this cycle with the CPU still held.
        state_nx   = S_RUN;
        cpu_rst_nx = 1'b0;
      end
      S_RUN: begin
        if (cpu_halt) begin
          state_nx = S_DONE;
          done_nx  = 1'b1;
        end else if (run_cycles != '1) begin
          run_cycles_nx = run_cycles + CW'(1);
        end
      end
      default: begin
        state_nx = S_IDLE;
      end
    endcase

    in_ready_nx = (state_nx == S_LOAD);
  end

endmodule

// File: tb/tb_program_loader.sv
// Testbench for program_loader: cycle table, directed multi-cycle sequences,
// and randomized loads checked against a transaction-level reference.
module tb_program_loader;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = '0;
  logic        in_last = 1'b0;
  logic        in_ready;
  logic        mem_wr;
  logic [4:0]  mem_addr;
  logic [7:0]  mem_data;
  logic        cpu_rst;
  logic        cpu_halt = 1'b0;
  logic        done;
  logic        error;
  logic [5:0]  byte_count;
  logic [15:0] run_cycles;

  int tests = 0;
  int fails = 0;

  logic [12:0] wq[$];

  program_loader #(.AW(5), .DW(8), .CW(16)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid),
    .in_data(in_data), .in_last(in_last), .in_ready(in_ready),
    .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_data(mem_data),
    .cpu_rst(cpu_rst), .cpu_halt(cpu_halt), .done(done), .error(error),
    .byte_count(byte_count), .run_cycles(run_cycles)
  );

  always #5 clk = ~clk;

  // Write monitor: every strobe observed between edges becomes one memory write.
  always @(negedge clk) if (mem_wr) wq.push_back({mem_addr, mem_data});

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_ready"}, in_ready, 0);
    check({tag, "_wr"}, mem_wr, 0);
    check({tag, "_addr"}, mem_addr, 0);
    check({tag, "_data"}, mem_data, 0);
    check({tag, "_cpu_rst"}, cpu_rst, 1);
    check({tag, "_done"}, done, 0);
    check({tag, "_error"}, error, 0);
    check({tag, "_bc"}, byte_count, 0);
    check({tag, "_run"}, run_cycles, 0);
  endtask

  typedef struct {
    logic        start, valid, last, halt;
    logic [7:0]  data;
    logic        e_ready, e_wr, e_rst, e_done, e_err;
    logic [4:0]  e_addr;
    logic [7:0]  e_dat;
    logic [5:0]  e_bc;
    logic [15:0] e_run;
  } vec_t;

  function automatic vec_t mk(input logic s, input logic v, input logic [7:0] d,
                              input logic l, input logic h, input logic er,
                              input logic ew, input logic [4:0] ea, input logic [7:0] ed,
                              input logic ers, input logic edn, input logic eer,
                              input logic [5:0] ebc, input logic [15:0] erun);
    vec_t r;
    r.start = s; r.valid = v; r.data = d; r.last = l; r.halt = h;
    r.e_ready = er; r.e_wr = ew; r.e_addr = ea; r.e_dat = ed;
    r.e_rst = ers; r.e_done = edn; r.e_err = eer; r.e_bc = ebc; r.e_run = erun;
    return r;
  endfunction

  // Reference for one load: the first min(n,32) bytes land at consecutive addresses,
  // overflow when no in_last arrives within 32 bytes, run length equals halt delay.
  task automatic scenario(input int n, input bit ovf, input int d, input bit gaps);
    logic [7:0] bytes[$];
    int acc, guard, exp_n;
    bit v, rdy;
    for (int k = 0; k < n; k++) bytes.push_back(8'($urandom));
    exp_n = ovf ? 32 : n;
    wq.delete();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("sc_err_clear", error, 0);
    check("sc_done_clear", done, 0);
    check("sc_load_ready", in_ready, 1);
    acc = 0;
    guard = 0;
    while (acc < n && guard < 2000) begin
      rdy = in_ready;
      if (!rdy) break;
      v = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
      in_valid = v;
      in_data = bytes[acc];
      in_last = !ovf && (acc == n - 1);
      @(negedge clk);
      if (v) acc++;
      guard++;
    end
    in_valid = 1'b0;
    in_last = 1'b0;
    check("sc_load_bound", guard < 2000, 1);
    check("sc_accepted", acc, exp_n);
    if (ovf) begin
      check("sc_ovf_error", error, 1);
      check("sc_ovf_cpu_rst", cpu_rst, 1);
      check("sc_ovf_ready", in_ready, 0);
      for (int k = 0; k < 4; k++) begin
        in_valid = 1'b1;
        in_data = 8'($urandom);
        cpu_halt = 1'($urandom);
        @(negedge clk);
      end
      in_valid = 1'b0;
      cpu_halt = 1'b0;
      check("sc_ovf_hold_error", error, 1);
      check("sc_ovf_no_done", done, 0);
      check("sc_ovf_hold_rst", cpu_rst, 1);
      check("sc_ovf_run", run_cycles, 0);
    end else begin
      check("sc_flush_cpu_rst", cpu_rst, 1);
      check("sc_flush_ready", in_ready, 0);
      cpu_halt = 1'($urandom);
      in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      check("sc_run_cpu_rst", cpu_rst, 0);
      check("sc_run_not_done", done, 0);
      for (int k = 0; k < d; k++) begin
        cpu_halt = 1'b0;
        in_valid = 1'($urandom);
        @(negedge clk);
      end
      cpu_halt = 1'b1;
      in_valid = 1'b0;
      @(negedge clk);
      cpu_halt = 1'b0;
      check("sc_done", done, 1);
      check("sc_run_cycles", run_cycles, d);
      check("sc_done_cpu_rst", cpu_rst, 0);
      check("sc_error_low", error, 0);
    end
    @(negedge clk);
    check("sc_byte_count", byte_count, exp_n);
    check("sc_write_count", wq.size(), exp_n);
    for (int k = 0; k < exp_n && k < wq.size(); k++)
      check($sformatf("sc_write_%0d", k), wq[k], {5'(k), bytes[k]});
  endtask

  vec_t tbl[14];

  initial begin
    tbl[0]  = mk(1, 0, 8'h00, 0, 0,  1, 0, 0, 8'h00, 1, 0, 0, 0, 0);
    tbl[1]  = mk(0, 1, 8'hA5, 0, 0,  1, 1, 0, 8'hA5, 1, 0, 0, 1, 0);
    tbl[2]  = mk(0, 1, 8'h3F, 1, 0,  0, 1, 1, 8'h3F, 1, 0, 0, 2, 0);
    tbl[3]  = mk(0, 0, 8'h00, 0, 1,  0, 0, 0, 8'h00, 0, 0, 0, 2, 0);
    tbl[4]  = mk(0, 1, 8'h55, 0, 0,  0, 0, 0, 8'h00, 0, 0, 0, 2, 1);
    tbl[5]  = mk(0, 0, 8'h00, 0, 0,  0, 0, 0, 8'h00, 0, 0, 0, 2, 2);
    tbl[6]  = mk(1, 0, 8'h00, 0, 0,  0, 0, 0, 8'h00, 0, 0, 0, 2, 3);
    tbl[7]  = mk(0, 0, 8'h00, 0, 1,  0, 0, 0, 8'h00, 0, 1, 0, 2, 3);
    tbl[8]  = mk(0, 1, 8'h77, 1, 0,  0, 0, 0, 8'h00, 0, 1, 0, 2, 3);
    tbl[9]  = mk(1, 0, 8'h00, 0, 0,  1, 0, 0, 8'h00, 1, 0, 0, 0, 0);
    tbl[10] = mk(0, 0, 8'h00, 0, 0,  1, 0, 0, 8'h00, 1, 0, 0, 0, 0);
    tbl[11] = mk(0, 1, 8'h11, 1, 0,  0, 1, 0, 8'h11, 1, 0, 0, 1, 0);
    tbl[12] = mk(1, 0, 8'h00, 0, 1,  0, 0, 0, 8'h00, 0, 0, 0, 1, 0);
    tbl[13] = mk(0, 0, 8'h00, 0, 1,  0, 0, 0, 8'h00, 0, 1, 0, 1, 0);

    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_vals("rst0");
    rst_n = 1'b1;

    for (int i = 0; i < 14; i++) begin
      start = tbl[i].start;
      in_valid = tbl[i].valid;
      in_data = tbl[i].data;
      in_last = tbl[i].last;
      cpu_halt = tbl[i].halt;
      @(negedge clk);
      check($sformatf("t%0d_ready", i), in_ready, tbl[i].e_ready);
      check($sformatf("t%0d_wr", i), mem_wr, tbl[i].e_wr);
      if (tbl[i].e_wr) begin
        check($sformatf("t%0d_addr", i), mem_addr, tbl[i].e_addr);
        check($sformatf("t%0d_data", i), mem_data, tbl[i].e_dat);
      end
      check($sformatf("t%0d_cpu_rst", i), cpu_rst, tbl[i].e_rst);
      check($sformatf("t%0d_done", i), done, tbl[i].e_done);
      check($sformatf("t%0d_error", i), error, tbl[i].e_err);
      check($sformatf("t%0d_bc", i), byte_count, tbl[i].e_bc);
      check($sformatf("t%0d_run", i), run_cycles, tbl[i].e_run);
    end
    start = 1'b0; in_valid = 1'b0; in_last = 1'b0; cpu_halt = 1'b0;

    scenario(2, 1'b0, 10, 1'b0);
    scenario(32, 1'b0, 5, 1'b0);
    scenario(32, 1'b1, 0, 1'b0);
    scenario(8, 1'b0, 3, 1'b1);
    scenario(36, 1'b1, 0, 1'b1);

    for (int it = 0; it < 25; it++) begin
      if ($urandom_range(0, 3) == 0)
        scenario($urandom_range(32, 36), 1'b1, 0, 1'($urandom));
      else
        scenario($urandom_range(1, 32), 1'b0, $urandom_range(0, 20), 1'($urandom));
    end

    // Reset in the middle of a load, with a byte in flight.
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < 3; k++) begin
      in_valid = 1'b1;
      in_data = 8'(8'hC0 + k);
      @(negedge clk);
    end
    check("midload_wr_active", mem_wr, 1);
    rst_n = 1'b0;
    @(negedge clk);
    check_reset_vals("midload");
    in_valid = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    check("midload_idle_ready", in_ready, 0);

    // Reset in the middle of a run.
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    in_valid = 1'b1; in_data = 8'h42; in_last = 1'b1;
    @(negedge clk);
    in_valid = 1'b0; in_last = 1'b0;
    repeat (5) @(negedge clk);
    check("midrun_cpu_rst", cpu_rst, 0);
    check("midrun_run", run_cycles, 4);
    rst_n = 1'b0;
    @(negedge clk);
    check_reset_vals("midrun");
    rst_n = 1'b1;
    cpu_halt = 1'b1;
    repeat (2) @(negedge clk);
    cpu_halt = 1'b0;
    check("idle_halt_ignored", done, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
